// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequences one temporal-unary multiply lane: streams the input as a thermometer code,
// drives the Sobol controls, counts returned product bits, and returns a signed result.
module mul_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [WIDTH-1:0] in_data_w,
  input  logic [WIDTH-1:0] in_len,
  output logic             o_bit_i,
  output logic [WIDTH-2:0] o_data_w,
  output logic             o_rng_clr,
  output logic             o_rng_en,
  input  logic             i_bit_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_data
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [WIDTH-1:0] LMAX = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] DL = WIDTH'(DP_LAT == 0 ? 0 : DP_LAT - 1);
  state_t state, nxt;
  logic [WIDTH-1:0] len, cnt, acc, acc_n, len_in;
  logic [WIDTH-2:0] mag_i;
  logic sign, accept, mark, run_end, drain_end;
  assign in_ready  = rst_n && state == IDLE;
  assign accept    = in_valid && in_ready;
  assign o_rng_clr = accept;
  assign run_end   = cnt == len - 1'b1;
  assign drain_end = cnt == DL;
  assign len_in    = (in_len == '0 || in_len > LMAX) ? LMAX : in_len;
  assign acc_n     = acc + WIDTH'(mark && i_bit_o);
  // mark flags cycles whose i_bit_o answers an o_bit_i issued DP_LAT cycles earlier
  if (DP_LAT == 0) begin : g_nolat
    assign mark = state == RUN;
  end else begin : g_lat
    logic [DP_LAT-1:0] sr;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sr <= '0;
      else sr <= (sr << 1) | DP_LAT'(state == RUN);
    assign mark = sr[DP_LAT-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  nxt = accept ? RUN : IDLE;
      RUN:   nxt = run_end ? (DP_LAT == 0 ? DONE : DRAIN) : RUN;
      DRAIN: nxt = drain_end ? DONE : DRAIN;
      DONE:  nxt = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len       <= '0;
      cnt       <= '0;
      acc       <= '0;
      mag_i     <= '0;
      sign      <= 1'b0;
      o_data_w  <= '0;
      o_bit_i   <= 1'b0;
      o_rng_en  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      acc <= accept ? '0 : acc_n;
      cnt <= (accept || (state == RUN && run_end)) ? '0 : cnt + 1'b1;
      if (accept) begin
        mag_i    <= in_data_i[WIDTH-2:0];
        o_data_w <= in_data_w[WIDTH-2:0];
        sign     <= in_data_i[WIDTH-1] ^ in_data_w[WIDTH-1];
        len      <= len_in;
      end
      o_bit_i   <= nxt == RUN && (accept ? in_data_i[WIDTH-2:0] != '0 : {1'b0, mag_i} > cnt + 1'b1);
      o_rng_en  <= nxt == RUN;
      out_valid <= nxt == DONE;
      if (nxt == DONE && state != DONE)
        out_data <= sign ? -{1'b0, acc_n} : {1'b0, acc_n};
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: table-driven directed checks of mul_seq_ctrl (WIDTH=8, DP_LAT=1) plus
// hand-written back-pressure and mid-run reset sequences.
module tb_mul_seq_ctrl;
  localparam int WIDTH = 8;
  localparam int DP_LAT = 1;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, lb = 0;
  logic [WIDTH-1:0] in_data_i = 0, in_data_w = 0, in_len = 0;
  logic o_bit_i, o_rng_clr, o_rng_en, i_bit_o, in_ready, out_valid;
  logic [WIDTH-2:0] o_data_w;
  logic [WIDTH:0] out_data;
  int mode = 0, errors = 0, checks = 0;

  mul_seq_ctrl #(.WIDTH(WIDTH), .DP_LAT(DP_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data_i(in_data_i), .in_data_w(in_data_w), .in_len(in_len),
    .o_bit_i(o_bit_i), .o_data_w(o_data_w), .o_rng_clr(o_rng_clr), .o_rng_en(o_rng_en),
    .i_bit_o(i_bit_o), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;
  // mode 2 models a cell of one-cycle latency echoing o_bit_i
  always @(posedge clk) lb <= o_bit_i;
  assign i_bit_o = mode == 2 ? lb : mode == 1;

  typedef struct {
    logic [7:0] di, dw, len;
    int mode, l, bits;
    logic [8:0] exp;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int hold);
    int clr, en, bits, rdy, lat, bad;
    logic [8:0] held;
    @(negedge clk);
    in_valid = 1; in_data_i = v.di; in_data_w = v.dw; in_len = v.len; mode = v.mode;
    #1;
    chk("accept_ready", int'(in_ready), 1);
    chk("accept_clr", int'(o_rng_clr), 1);
    @(posedge clk); #1 in_valid = 0;
    clr = 0; en = 0; bits = 0; rdy = 0; lat = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      clr += int'(o_rng_clr); en += int'(o_rng_en); bits += int'(o_bit_i); rdy += int'(in_ready);
      if (out_valid) begin lat = n; break; end
    end
    chk("latency", lat, v.l + DP_LAT + 1);
    chk("out_data", int'(out_data), int'(v.exp));
    chk("rng_en_cycles", en, v.l);
    chk("bit_i_ones", bits, v.bits);
    chk("extra_clr_or_ready", clr + rdy, 0);
    chk("data_w", int'(o_data_w), int'(v.dw[6:0]));
    held = out_data; bad = 0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      in_valid = k[0]; #1;
      if (!out_valid || out_data !== held || in_ready || o_rng_clr) bad++;
    end
    in_valid = 0;
    if (hold > 0) chk("hold_stable", bad, 0);
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
    chk("post_valid", int'(out_valid), 0);
    chk("post_ready", int'(in_ready), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_outs"}, int'({o_bit_i, o_rng_clr, o_rng_en, out_valid, in_ready}), 0);
    chk({tag, "_data"}, int'({o_data_w, out_data}), 0);
  endtask

  initial begin
    vec_t vt[12];
    vt[0]  = '{8'h05, 8'h03, 8'h00, 1, 128, 5,   9'h080};
    vt[1]  = '{8'h05, 8'h03, 8'h10, 2, 16,  5,   9'h005};
    vt[2]  = '{8'h85, 8'h03, 8'h10, 2, 16,  5,   9'h1FB};
    vt[3]  = '{8'h85, 8'h83, 8'h10, 2, 16,  5,   9'h005};
    vt[4]  = '{8'h80, 8'h03, 8'h10, 2, 16,  0,   9'h000};
    vt[5]  = '{8'h01, 8'h03, 8'h01, 1, 1,   1,   9'h001};
    vt[6]  = '{8'h7F, 8'h03, 8'hC8, 2, 128, 127, 9'h07F};
    vt[7]  = '{8'h7F, 8'h83, 8'h64, 2, 100, 100, 9'h19C};
    vt[8]  = '{8'h0A, 8'h03, 8'h14, 0, 20,  10,  9'h000};
    vt[9]  = '{8'h0A, 8'h03, 8'h08, 2, 8,   8,   9'h008};
    vt[10] = '{8'h81, 8'h81, 8'h81, 2, 128, 1,   9'h001};
    vt[11] = '{8'h00, 8'h80, 8'h80, 1, 128, 0,   9'h180};
    #1;
    chk_reset_outputs("reset");
    #22 rst_n = 1;
    @(negedge clk);
    chk("idle_ready", int'(in_ready), 1);
    for (int i = 0; i < 12; i++) run_op(vt[i], 0);
    run_op('{8'h03, 8'h05, 8'h04, 2, 4, 3, 9'h003}, 10);
    // abort mid-RUN at cnt==7, then verify a clean follow-up result
    @(negedge clk);
    in_valid = 1; in_data_i = 8'h0A; in_data_w = 8'h03; in_len = 8'h10; mode = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (8) @(negedge clk);
    chk("pre_abort_en", int'(o_rng_en), 1);
    rst_n = 0; #1;
    chk_reset_outputs("abort");
    @(negedge clk); rst_n = 1;
    run_op('{8'h06, 8'h03, 8'h10, 2, 16, 6, 9'h006}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencing controller for one unary-temporal multiply lane built around the temporal-unary multiplier cell.
- Accepts a sign-magnitude input/weight pair over a valid/ready handshake.
- Emits the input operand as a temporal (thermometer) bitstream over a programmable number of cycles.
- Drives the Sobol random-number generator's clear/advance controls and presents the weight magnitude to the cell.
- Counts the product bits the cell returns, then hands back a signed result over a second valid/ready handshake.

## Interface
Parameters:
- WIDTH, 8, operand width in sign-magnitude; magnitude is WIDTH-1 bits.
- DP_LAT, 1, cycles from an issued o_bit_i to the matching i_bit_o (0..4).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept an operand pair.
- in_data_i  input  WIDTH  input operand; MSB sign, low WIDTH-1 bits magnitude.
- in_data_w  input  WIDTH  weight operand; same encoding.
- in_len  input  WIDTH  stream length L in cycles, sampled with in_valid&in_ready; 0 means 2^(WIDTH-1); values above 2^(WIDTH-1) clamp to 2^(WIDTH-1).
- o_bit_i  output  1  temporal input bit to the cell.
- o_data_w  output  WIDTH-1  registered weight magnitude to the cell.
- o_rng_clr  output  1  one-cycle Sobol restart pulse.
- o_rng_en  output  1  Sobol advance enable.
- i_bit_o  input  1  product bit from the cell.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumer ready.
- out_data  output  WIDTH+1  two's-complement signed count of product ones.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch mag_i, mag_w, sign = sign_i XOR sign_w, and L.
  - Clear cnt and acc; pulse o_rng_clr for that cycle; go to RUN.
- RUN:
  - Lasts exactly L cycles; cnt runs 0..L-1.
  - o_bit_i = (cnt < mag_i); o_rng_en=1.
  - On cnt==L-1, go to DRAIN, or straight to DONE when DP_LAT=0.
- DRAIN:
  - Lasts DP_LAT cycles; o_bit_i=0, o_rng_en=0.
  - Counter reaching DP_LAT-1 moves to DONE.
- Capture:
  - A DP_LAT-deep shift register of the RUN flag marks which cycles carry valid i_bit_o.
  - acc += i_bit_o only in marked cycles. i_bit_o is ignored in every other cycle, including IDLE and DONE.
- acc is WIDTH bits unsigned, max 2^(WIDTH-1); no overflow possible.
- DONE:
  - out_valid=1; out_data = sign ? -acc : acc, sign-extended to WIDTH+1 bits; acc=0 always yields +0.
  - out_valid and out_data hold stable until out_ready; then go to IDLE.
  - in_ready stays 0 during RUN, DRAIN and DONE; no accept in the same cycle as the result handshake.
- o_data_w holds the latched mag_w from accept until the next accept.
- Reset values: in_ready=0 during reset, then 1 in IDLE; o_bit_i=0, o_data_w=0, o_rng_clr=0, o_rng_en=0, out_valid=0, out_data=0, state=IDLE.
- Reset mid-operation aborts immediately; no partial result is produced.

## Timing
- Accept edge E0. RUN occupies cycles E0+1..E0+L; o_rng_clr is high in cycle E0 (combinational with the accept).
- DRAIN occupies cycles E0+L+1..E0+L+DP_LAT.
- out_valid first high in cycle E0+L+DP_LAT+1.
- Back-to-back throughput: one operation per L+DP_LAT+2 cycles with out_ready tied high.
- All outputs except o_rng_clr and in_ready are registered.

## Test plan
- Tie i_bit_o=1, in_len=0, WIDTH=8, DP_LAT=1, positive operands -> out_data=+128 at E0+130; exactly 128 o_rng_en cycles; one o_rng_clr pulse at E0.
- mag_i=5, L=16, i_bit_o looped from a one-cycle-delayed o_bit_i -> o_bit_i high for the first 5 RUN cycles only; out_data=+5.
- Same as the previous scenario with sign_i=1, sign_w=0 -> out_data=-5 (9'h1FB). With both signs 1 -> +5. With mag_i=0 and sign 1 -> 0.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, in_valid pulses ignored; accept on release; IDLE next cycle.
- Assert rst_n=0 mid-RUN at cnt=7 -> all outputs at reset values asynchronously; next operation produces a correct, uncontaminated count.
- Drive i_bit_o=1 outside the capture window (IDLE, DONE, and the first RUN cycle when DP_LAT=1) -> no effect on out_data; L=1, mag_i=1 -> out_data=+1.
